// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore control FSM sequencing fetch, decode, ALU and load/store steps
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset (forces RST)
//   opcode[2:0], op[1:0] instruction fields IR[15:13] / IR[12:11]
//   load_pc, reset_pc   program counter controls
//   addr_sel            1 = PC drives the memory address, 0 = address register
//   load_ir, load_addr  instruction / data-address register loads
//   mem_cmd[1:0]        00 NONE, 01 READ, 10 WRITE
//   nsel[1:0]           register select: 00 Rn, 01 Rd, 10 Rm
//   vsel[1:0]           writeback source: 00 C, 10 sximm8, 11 mdata
//   write, loada, loadb, asel, bsel, loadc, loads  datapath controls
//   halted              high while in HALT
//
// Parameter RD_LAT (1..15) sets how many cycles IF1 and MRD hold a read.
// Optional macro CPU_CONTROLLER_HALT_EN: opcode 111 enters HALT until reset;
// without it opcode 111 is a NOP and halted stays 0.

module cpu_controller #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_ir,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_EXEC,
    S_WREG, S_ADDR, S_LDAD, S_MRD, S_WMEM, S_STB, S_STOUT, S_MWR, S_HALT
  } state_t;

  typedef struct packed {
    logic       halted;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_ir;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
  } ctrl_t;

  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] SEL_RN    = 2'b00;
  localparam logic [1:0] SEL_RD    = 2'b01;
  localparam logic [1:0] SEL_RM    = 2'b10;
  localparam logic [1:0] V_C       = 2'b00;
  localparam logic [1:0] V_IMM8    = 2'b10;
  localparam logic [1:0] V_MDATA   = 2'b11;
  localparam logic [3:0] LAT_LAST  = 4'(RD_LAT - 1);

  state_t     state, nxt;
  logic [3:0] cnt, nxt_cnt;
  logic       phase, nxt_phase;   // ADDR second cycle; kept apart so cnt stays below RD_LAT
  logic [2:0] ir_opc;             // fields captured in DEC; later branches use only these
  logic [1:0] ir_op;
  ctrl_t      ctrl;

  // Output pattern for a state; the registered copy tracks the state one-for-one.
  function automatic ctrl_t decode(input state_t s, input logic ph,
                                   input logic [2:0] opc, input logic [1:0] o);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
      S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      S_UPC:   c.load_pc = 1'b1;
      S_WIMM:  begin c.nsel = SEL_RN; c.vsel = V_IMM8; c.write = 1'b1; end
      S_GETA:  begin c.nsel = SEL_RN; c.loada = 1'b1; end
      S_GETB:  begin c.nsel = SEL_RM; c.loadb = 1'b1; end
      S_EXEC:  begin
        c.loadc = 1'b1;
        c.asel  = (opc == 3'b110);
        c.loads = (opc == 3'b101) && (o == 2'b01);
      end
      S_WREG:  begin c.nsel = SEL_RD; c.vsel = V_C; c.write = 1'b1; end
      S_ADDR:  begin
        if (!ph) begin c.nsel = SEL_RN; c.loada = 1'b1; end
        else     begin c.bsel = 1'b1;   c.loadc = 1'b1; end
      end
      S_LDAD:  c.load_addr = 1'b1;
      S_MRD:   c.mem_cmd = MEM_READ;
      S_WMEM:  begin c.mem_cmd = MEM_READ; c.nsel = SEL_RD; c.vsel = V_MDATA; c.write = 1'b1; end
      S_STB:   begin c.nsel = SEL_RD; c.loadb = 1'b1; end
      S_STOUT: begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MWR:   c.mem_cmd = MEM_WRITE;
      S_HALT:  begin
`ifdef CPU_CONTROLLER_HALT_EN
        c.halted = 1'b1;
`endif
      end
      default: ;
    endcase
    return c;
  endfunction

  // Counter and phase fall to 0 unless the state is held, so any state change clears them.
  always_comb begin
    nxt       = state;
    nxt_cnt   = 4'd0;
    nxt_phase = 1'b0;
    case (state)
      S_RST:   nxt = S_IF1;
      S_IF1:   if (cnt == LAT_LAST) nxt = S_IF2; else nxt_cnt = cnt + 4'd1;
      S_IF2:   nxt = S_UPC;
      S_UPC:   nxt = S_DEC;
      S_DEC:   begin
        casez ({opcode, op})
          5'b110_10:          nxt = S_WIMM;
          5'b110_00:          nxt = S_GETB;
          5'b101_??:          nxt = S_GETA;
          5'b011_00, 5'b100_00: nxt = S_ADDR;
`ifdef CPU_CONTROLLER_HALT_EN
          5'b111_??:          nxt = S_HALT;
`endif
          default:            nxt = S_IF1;
        endcase
      end
      S_WIMM:  nxt = S_IF1;
      S_GETA:  nxt = S_GETB;
      S_GETB:  nxt = S_EXEC;
      S_EXEC:  nxt = (ir_opc == 3'b101 && ir_op == 2'b01) ? S_IF1 : S_WREG;
      S_WREG:  nxt = S_IF1;
      S_ADDR:  if (!phase) nxt_phase = 1'b1; else nxt = S_LDAD;
      S_LDAD:  nxt = (ir_opc == 3'b011) ? S_MRD : S_STB;
      S_MRD:   if (cnt == LAT_LAST) nxt = S_WMEM; else nxt_cnt = cnt + 4'd1;
      S_WMEM:  nxt = S_IF1;
      S_STB:   nxt = S_STOUT;
      S_STOUT: nxt = S_MWR;
      S_MWR:   nxt = S_IF1;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_RST;
      cnt    <= 4'd0;
      phase  <= 1'b0;
      ir_opc <= 3'd0;
      ir_op  <= 2'd0;
      ctrl   <= decode(S_RST, 1'b0, 3'd0, 2'd0);
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      phase <= nxt_phase;
      if (state == S_DEC) begin
        ir_opc <= opcode;
        ir_op  <= op;
      end
      ctrl <= decode(nxt, nxt_phase, ir_opc, ir_op);
    end
  end

  assign load_pc   = ctrl.load_pc;
  assign reset_pc  = ctrl.reset_pc;
  assign addr_sel  = ctrl.addr_sel;
  assign load_ir   = ctrl.load_ir;
  assign load_addr = ctrl.load_addr;
  assign mem_cmd   = ctrl.mem_cmd;
  assign nsel      = ctrl.nsel;
  assign vsel      = ctrl.vsel;
  assign write     = ctrl.write;
  assign loada     = ctrl.loada;
  assign loadb     = ctrl.loadb;
  assign asel      = ctrl.asel;
  assign bsel      = ctrl.bsel;
  assign loadc     = ctrl.loadc;
  assign loads     = ctrl.loads;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller with random instruction streams

module tb_cpu_controller;

  localparam int LAT = 3;
`ifdef CPU_CONTROLLER_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic [1:0] op = 2'd0;
  logic       load_pc, reset_pc, addr_sel, load_ir, load_addr;
  logic [1:0] mem_cmd, nsel, vsel;
  logic       write, loada, loadb, asel, bsel, loadc, loads, halted;

  always #5 clk = ~clk;

  cpu_controller #(.RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel), .load_ir(load_ir),
    .load_addr(load_addr), .mem_cmd(mem_cmd), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
    .loads(loads), .halted(halted)
  );

  typedef struct packed {
    logic       halted, load_pc, reset_pc, addr_sel, load_ir, load_addr;
    logic [1:0] mem_cmd, nsel, vsel;
    logic       write, loada, loadb, asel, bsel, loadc, loads;
  } vec_t;

  vec_t act;
  assign act = vec_t'({halted, load_pc, reset_pc, addr_sel, load_ir, load_addr,
                       mem_cmd, nsel, vsel, write, loada, loadb, asel, bsel, loadc, loads});

  vec_t       exp_q[$];
  string      tag_q[$];
  logic [4:0] stim_q[$];
  int compared = 0;
  int mismatched = 0;

  // Monitor: one expected vector per cycle while a program is running.
  always @(negedge clk) begin
    vec_t  e;
    string t;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h", t, act, e);
      end
    end
  end

  // Driver: instruction fields for each cycle; only the DEC slot carries the real instruction.
  always @(negedge clk) begin
    if (!reset && stim_q.size() > 0) {opcode, op} = stim_q.pop_front();
  end

  function automatic logic [4:0] junk();
    return 5'($urandom);
  endfunction

  task automatic emit(input vec_t v, input string t, input logic [4:0] s);
    exp_q.push_back(v);
    tag_q.push_back(t);
    stim_q.push_back(s);
  endtask

  task automatic flush();
    exp_q.delete();
    tag_q.delete();
    stim_q.delete();
  endtask

  function automatic vec_t rst_vec();
    vec_t v;
    v = '0; v.reset_pc = 1'b1; v.load_pc = 1'b1;
    return v;
  endfunction

  // Reference: the cycle-by-cycle output trace of one instruction, fetch included.
  task automatic model_instr(input logic [2:0] oc, input logic [1:0] o);
    vec_t  v;
    string id;
    bit    cmp;
    id = $sformatf("%b/%b", oc, o);
    repeat (LAT) begin
      v = '0; v.addr_sel = 1; v.mem_cmd = 2'b01; emit(v, {"IF1 ", id}, junk());
    end
    v = '0; v.addr_sel = 1; v.mem_cmd = 2'b01; v.load_ir = 1; emit(v, {"IF2 ", id}, junk());
    v = '0; v.load_pc = 1; emit(v, {"UPC ", id}, junk());
    v = '0; emit(v, {"DEC ", id}, {oc, o});
    cmp = (oc == 3'd5 && o == 2'd1);
    if (oc == 3'd6 && o == 2'd2) begin
      v = '0; v.nsel = 2'b00; v.vsel = 2'b10; v.write = 1; emit(v, {"WIMM ", id}, junk());
    end else if ((oc == 3'd6 && o == 2'd0) || oc == 3'd5) begin
      if (oc == 3'd5) begin
        v = '0; v.nsel = 2'b00; v.loada = 1; emit(v, {"GETA ", id}, junk());
      end
      v = '0; v.nsel = 2'b10; v.loadb = 1; emit(v, {"GETB ", id}, junk());
      v = '0; v.loadc = 1; v.asel = (oc == 3'd6); v.loads = cmp; emit(v, {"EXEC ", id}, junk());
      if (!cmp) begin
        v = '0; v.nsel = 2'b01; v.vsel = 2'b00; v.write = 1; emit(v, {"WREG ", id}, junk());
      end
    end else if ((oc == 3'd3 || oc == 3'd4) && o == 2'd0) begin
      v = '0; v.nsel = 2'b00; v.loada = 1; emit(v, {"ADDR0 ", id}, junk());
      v = '0; v.bsel = 1; v.loadc = 1; emit(v, {"ADDR1 ", id}, junk());
      v = '0; v.load_addr = 1; emit(v, {"LDAD ", id}, junk());
      if (oc == 3'd3) begin
        repeat (LAT) begin
          v = '0; v.mem_cmd = 2'b01; emit(v, {"MRD ", id}, junk());
        end
        v = '0; v.mem_cmd = 2'b01; v.nsel = 2'b01; v.vsel = 2'b11; v.write = 1;
        emit(v, {"WMEM ", id}, junk());
      end else begin
        v = '0; v.nsel = 2'b01; v.loadb = 1; emit(v, {"STB ", id}, junk());
        v = '0; v.asel = 1; v.loadc = 1; emit(v, {"STOUT ", id}, junk());
        v = '0; v.mem_cmd = 2'b10; emit(v, {"MWR ", id}, junk());
      end
    end else if (oc == 3'd7 && HALT_EN) begin
      repeat (20) begin
        v = '0; v.halted = 1; emit(v, {"HALT ", id}, junk());
      end
    end
  endtask

  task automatic random_instr();
    case ($urandom_range(0, 6))
      0: model_instr(3'd6, 2'd2);
      1: model_instr(3'd6, 2'd0);
      2: model_instr(3'd5, 2'd0);
      3: model_instr(3'd5, 2'd1);
      4: model_instr(3'd3, 2'd0);
      5: model_instr(3'd4, 2'd0);
      default: model_instr(3'($urandom_range(0, HALT_EN ? 6 : 7)), 2'($urandom_range(0, 3)));
    endcase
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 5000 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
    end
  endtask

  // Reset released between edges so the first monitored cycle is RST.
  task automatic run_program(input int n, input bit halt_last);
    reset = 1'b1;
    flush();
    @(posedge clk);
    #2;
    emit(rst_vec(), "RST", junk());
    for (int k = 0; k < n; k++) random_instr();
    if (halt_last) begin
      model_instr(3'd7, 2'($urandom_range(0, 3)));
      if (!HALT_EN) model_instr(3'd6, 2'd2);
    end
    reset = 1'b0;
    wait_drain();
  endtask

  initial begin
    bit found;
    run_program(40, 1'b0);
    run_program(10, 1'b1);

    // Asynchronous reset in the middle of a multi-cycle memory read.
    reset = 1'b1;
    flush();
    @(posedge clk);
    #2;
    emit(rst_vec(), "RST", junk());
    model_instr(3'd3, 2'd0);
    reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (mem_cmd == 2'b01 && !addr_sel && !write) found = 1'b1;
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL mrd_wait: got no MRD cycle expected one within 100 cycles");
    end else begin
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      if (act !== rst_vec()) begin
        mismatched++;
        $display("FAIL async_reset: got %h expected %h", act, rst_vec());
      end
    end
    flush();

    run_program(15, 1'b1);
    run_program(25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
